// File: rtl/collision_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | collision_scanner: per-player probe-vs-box-table scanner, wall flags  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module collision_scanner #(
  parameter int NUM_BOXES = 8,
  parameter int ADDR_W    = 3,
  parameter int PLAYER_W  = 16,
  parameter int PLAYER_H  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       position,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [63:0]       cfg_data,
  input  logic              cfg_platform,
  input  logic              cfg_enable,
  output logic [31:0]       wall,
  output logic              wall_valid
);

  typedef enum logic [0:0] {LOAD = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(NUM_BOXES - 1);
  localparam logic [16:0]       C_W    = 17'(PLAYER_W);
  localparam logic [16:0]       C_H    = 17'(PLAYER_H);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       sx_q, sx_d, sy_q, sy_d;
  logic [4:0]        acc_q, acc_d;
  logic [4:0]        wall_q, wall_d;
  logic              wall_valid_q, wall_valid_d;

  logic [63:0]          bounds_q [NUM_BOXES];
  logic [63:0]          bounds_d [NUM_BOXES];
  logic [NUM_BOXES-1:0] plat_q, plat_d, en_q, en_d;

  logic        cfg_ok;
  logic [63:0] cur;
  logic [16:0] bx0, by0, bx1, by1;
  logic [16:0] sx17, sy17, down_row, up_row, left_col, right_col;
  logic        box_ok, col_span, row_span;
  logic        hit_up, hit_down, hit_left, hit_right;
  logic [4:0]  hits;

  always_comb begin
    bounds_d = bounds_q;
    plat_d   = plat_q;
    en_d     = en_q;
    cfg_ok   = cfg_we && ({{(32-ADDR_W){1'b0}}, cfg_addr} < 32'(NUM_BOXES));
    if (cfg_ok) begin
      bounds_d[cfg_addr] = cfg_data;
      plat_d[cfg_addr]   = cfg_platform;
      en_d[cfg_addr]     = cfg_enable;
    end
  end

  // All probe math is 17-bit: an underflow wraps to 0x1FFFF and anything
  // past 65535 exceeds every 16-bit box bound, so neither can ever hit.
  always_comb begin
    cur       = bounds_q[idx_q];
    bx0       = {1'b0, cur[63:48]};
    by0       = {1'b0, cur[47:32]};
    bx1       = {1'b0, cur[31:16]};
    by1       = {1'b0, cur[15:0]};
    sx17      = {1'b0, sx_q};
    sy17      = {1'b0, sy_q};
    down_row  = sy17 - 17'd1;
    up_row    = sy17 + C_H;
    left_col  = sx17 - 17'd1;
    right_col = sx17 + C_W;
    box_ok    = (bx0 <= bx1) && (by0 <= by1);
    col_span  = (sx17 <= bx1) && ((sx17 + C_W - 17'd1) >= bx0);
    row_span  = (sy17 <= by1) && ((sy17 + C_H - 17'd1) >= by0);
    hit_down  = box_ok && col_span && (down_row >= by0) && (down_row <= by1);
    hit_up    = box_ok && col_span && (up_row >= by0) && (up_row <= by1);
    hit_left  = box_ok && row_span && (left_col >= bx0) && (left_col <= bx1);
    hit_right = box_ok && row_span && (right_col >= bx0) && (right_col <= bx1);
    hits      = 5'b0;
    if (en_q[idx_q]) begin
      if (plat_q[idx_q]) hits = {hit_down && (down_row == by1), 4'b0};
      else               hits = {1'b0, hit_left, hit_right, hit_down, hit_up};
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    acc_d        = acc_q;
    wall_d       = wall_q;
    wall_valid_d = 1'b0;
    unique case (state_q)
      LOAD: begin
        sx_d    = position[31:16];
        sy_d    = position[15:0];
        acc_d   = 5'b0;
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (idx_q == C_LAST) begin
          wall_d       = acc_q | hits;
          wall_valid_d = 1'b1;
          idx_d        = '0;
          state_d      = LOAD;
        end else begin
          acc_d = acc_q | hits;
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      acc_q        <= '0;
      wall_q       <= '0;
      wall_valid_q <= 1'b0;
      bounds_q     <= '{default: '0};
      plat_q       <= '0;
      en_q         <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      acc_q        <= acc_d;
      wall_q       <= wall_d;
      wall_valid_q <= wall_valid_d;
      bounds_q     <= bounds_d;
      plat_q       <= plat_d;
      en_q         <= en_d;
    end
  end

  assign wall       = {27'b0, wall_q};
  assign wall_valid = wall_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_collision_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_collision_scanner: scoreboard bench for collision_scanner          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_collision_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] position = 32'h0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [63:0] cfg_data = 64'h0;
  logic        cfg_platform = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [31:0] wall;
  logic        wall_valid;

  collision_scanner #(.NUM_BOXES(8), .ADDR_W(3), .PLAYER_W(16), .PLAYER_H(16)) dut (
    .clock(clock), .reset(reset), .position(position),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_platform(cfg_platform), .cfg_enable(cfg_enable),
    .wall(wall), .wall_valid(wall_valid)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic chk; logic [31:0] val;} exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per wall_valid pulse and checks the period.
  int gap = 0;
  bit have_prev = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      gap = 0;
      have_prev = 1'b0;
    end else begin
      gap++;
      if (wall_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got wall 0x%08h with no expectation queued", wall);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.chk) check("wall", wall, e.val);
        end
        if (have_prev) check("period", 32'(gap), 32'd9);
        gap = 0;
        have_prev = 1'b1;
      end
    end
  end

  task automatic wait_pulse();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!wall_valid && n < 40);
    if (!wall_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pulse_timeout: got no wall_valid in %0d cycles, want one within 9", n);
    end
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [15:0] x0, input logic [15:0] y0,
                           input logic [15:0] x1, input logic [15:0] y1,
                           input logic plat, input logic en);
    cfg_addr     = addr;
    cfg_data     = {x0, y0, x1, y1};
    cfg_platform = plat;
    cfg_enable   = en;
    cfg_we       = 1'b1;
    @(negedge clock);
    cfg_we       = 1'b0;
  endtask

  // At a pulse, set the position that the next pass snapshots and queue its result.
  task automatic run(input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp);
    wait_pulse();
    position = {x, y};
    sb.push_back('{1'b1, exp});
  endtask

  task automatic cfg_pass();
    wait_pulse();
    sb.push_back('{1'b0, 32'h0});
  endtask

  initial begin
    position = {16'd1000, 16'd1000};
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_wall", wall, 32'h0);
    check("reset_valid", {31'b0, wall_valid}, 32'h0);
    sb.push_back('{1'b1, 32'h0});
    reset = 1'b0;

    run(16'd1000, 16'd1000, 32'h0);

    cfg_pass();
    cfg_write(3'd0, 16'd0, 16'd0, 16'd255, 16'd31, 1'b0, 1'b1);
    run(16'd100, 16'd32, 32'h2);
    repeat (3) @(negedge clock);
    position = {16'd5000, 16'd5000};
    run(16'd100, 16'd40, 32'h0);

    cfg_pass();
    cfg_write(3'd1, 16'd50, 16'd100, 16'd150, 16'd103, 1'b1, 1'b1);
    run(16'd60, 16'd104, 32'h10);
    run(16'd60, 16'd103, 32'h0);
    run(16'd60, 16'd105, 32'h0);

    cfg_pass();
    cfg_write(3'd2, 16'd200, 16'd0, 16'd210, 16'd255, 1'b0, 1'b1);
    run(16'd184, 16'd50, 32'h4);
    run(16'd183, 16'd50, 32'h0);
    run(16'd211, 16'd50, 32'h8);

    cfg_pass();
    cfg_write(3'd0, 16'd0, 16'd0, 16'd100, 16'd0, 1'b0, 1'b1);
    cfg_write(3'd3, 16'd65530, 16'd0, 16'd65535, 16'd65535, 1'b0, 1'b1);
    cfg_write(3'd4, 16'd0, 16'd0, 16'd65535, 16'd65535, 1'b0, 1'b0);
    run(16'd0, 16'd0, 32'h4);
    run(16'd65520, 16'd500, 32'h3);
    run(16'd65535, 16'd65535, 32'hA);

    // Mid-scan writes: box7 lands before its slot, box0 after its slot.
    wait_pulse();
    position = {16'd1000, 16'd1000};
    sb.push_back('{1'b1, 32'h1});
    repeat (4) @(negedge clock);
    cfg_write(3'd7, 16'd1000, 16'd1016, 16'd1000, 16'd1016, 1'b0, 1'b1);
    @(negedge clock);
    cfg_write(3'd0, 16'd0, 16'd0, 16'd999, 16'd65535, 1'b0, 1'b1);
    wait_pulse();
    sb.push_back('{1'b1, 32'h9});

    // Reset at scan index 4, colliding with a config write that must be dropped.
    wait_pulse();
    repeat (5) @(negedge clock);
    reset        = 1'b1;
    cfg_addr     = 3'd5;
    cfg_data     = {16'd0, 16'd0, 16'd65535, 16'd65535};
    cfg_platform = 1'b0;
    cfg_enable   = 1'b1;
    cfg_we       = 1'b1;
    @(negedge clock);
    cfg_we = 1'b0;
    check("midreset_wall", wall, 32'h0);
    check("midreset_valid", {31'b0, wall_valid}, 32'h0);
    sb.push_back('{1'b1, 32'h0});
    reset = 1'b0;
    run(16'd1000, 16'd1000, 32'h0);
    run(16'd1000, 16'd1000, 32'h0);
    wait_pulse();
    #1;
    check("queue_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
